// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI slave that turns serial frames into register strobes.
//
// Frame: cs_n low, 8-bit header (bit7 = 1 write / 0 read, low ADDR_W bits =
// start address), then any number of DATA_W-bit data words. The address
// auto-increments after every completed word, so long frames are bursts.
//
// Ports
//   clk, rst_n          peripheral clock, asynchronous active-low reset
//   sclk, cs_n, mosi    SPI master signals (asynchronous to clk)
//   miso, miso_oe       serial read data and its output enable
//   wr_en, wr_data      one-clk write strobe and write word
//   rd_en, rd_data      one-clk read strobe; rd_data is sampled 1 clk later
//   addr                register address, valid with wr_en / rd_en
//   busy                a frame is in progress
//   frame_err           one-clk pulse when cs_n rises with a partial word
module spi_reg_bridge #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int   CNT_W     = $clog2(DATA_W) + 1;
    localparam logic SCLK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, HEADER, WR_DATA, RD_DATA} state_t;

    // Input synchronizers, preset to the bus idle levels.
    logic       sclk_s1_q, sclk_s2_q, sclk_old_q;
    logic       cs_s1_q, cs_s2_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q  <= SCLK_IDLE;
            sclk_s2_q  <= SCLK_IDLE;
            sclk_old_q <= SCLK_IDLE;
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            flush_q    <= 2'b00;
        end else begin
            sclk_s1_q  <= sclk;
            sclk_s2_q  <= sclk_s1_q;
            sclk_old_q <= sclk_s2_q;
            cs_s1_q    <= cs_n;
            cs_s2_q    <= cs_s1_q;
            mosi_s1_q  <= mosi;
            mosi_s2_q  <= mosi_s1_q;
            flush_q    <= {flush_q[0], 1'b1};
        end
    end

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;

    assign sclk_rise   = ~sclk_old_q & sclk_s2_q;
    assign sclk_fall   = sclk_old_q & ~sclk_s2_q;
    assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                ld_q, ld_d;
    logic                frame_err_q, frame_err_d;
    logic                cs_armed_q, cs_armed_d;
    logic [DATA_W-1:0]   word_in;

    assign word_in = {sh_q[DATA_W-2:0], mosi_s2_q};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        ld_d        = rd_en_q;
        frame_err_d = 1'b0;
        // A frame may only start after cs_n has been seen high with the
        // synchronizer flushed, so a cs_n held low across reset is ignored.
        cs_armed_d  = cs_armed_q | (flush_q[1] & cs_s2_q);

        // addr stays stable while wr_en is high and advances right after.
        if (wr_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        if (ld_q) begin
            tx_d = rd_data;
        end

        case (state_q)
            IDLE: begin
                if (cs_armed_q && !cs_s2_q) begin
                    state_d    = HEADER;
                    cs_armed_d = 1'b0;
                    bit_cnt_d  = '0;
                    sh_d       = '0;
                end
            end
            default: begin
                if (cs_s2_q) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                end else begin
                    if (sample_edge) begin
                        case (state_q)
                            HEADER: begin
                                sh_d = word_in;
                                if (bit_cnt_q == CNT_W'(7)) begin
                                    bit_cnt_d = '0;
                                    addr_d    = word_in[ADDR_W-1:0];
                                    if (word_in[7]) begin
                                        state_d = WR_DATA;
                                    end else begin
                                        state_d = RD_DATA;
                                        rd_en_d = 1'b1;
                                    end
                                end else begin
                                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                                end
                            end
                            WR_DATA: begin
                                sh_d = word_in;
                                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                                    bit_cnt_d = '0;
                                    wr_data_d = word_in;
                                    wr_en_d   = 1'b1;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                                end
                            end
                            RD_DATA: begin
                                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                                    bit_cnt_d = '0;
                                    addr_d    = addr_q + ADDR_W'(1);
                                    rd_en_d   = 1'b1;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                    // The shift edge before a word's first sample (or the one
                    // closing the previous word) must keep the freshly loaded
                    // MSB on miso, hence the bit-count qualifier.
                    if (state_q == RD_DATA && shift_edge && bit_cnt_q != '0) begin
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            ld_q        <= 1'b0;
            frame_err_q <= 1'b0;
            cs_armed_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            ld_q        <= ld_d;
            frame_err_q <= frame_err_d;
            cs_armed_q  <= cs_armed_d;
        end
    end

    assign miso_oe   = (state_q == RD_DATA);
    assign miso      = miso_oe & tx_q[DATA_W-1];
    assign busy      = (state_q != IDLE);
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule
